// File: rtl/top_result_accumulator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : top_result_accumulator_pkg                                     |
// | Brief   : Result-word field positions, FSM states and error bit indices. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package top_result_accumulator_pkg;

  localparam int RESULT_SUM_LSB    = 0;
  localparam int RESULT_SUM_MSB    = 37;
  localparam int RESULT_PCOEFF_LSB = 48;
  localparam int RESULT_PCOEFF_MSB = 50;

  localparam int ERR_BADSTART = 0;
  localparam int ERR_STRAY    = 1;
  localparam int ERR_OVERFLOW = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/top_result_accumulator_hold.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : top_result_accumulator_hold                                    |
// | Brief   : Single-entry valid/ready holding register for per-top totals.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module top_result_accumulator_hold #(
  parameter int COUNT_W  = 32,
  parameter int SUM_W    = 64,
  parameter int PCOEFF_W = 40
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                load_i,
  input  logic [SUM_W-1:0]    sum_i,
  input  logic [PCOEFF_W-1:0] pcoeff_i,
  input  logic [COUNT_W-1:0]  count_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [SUM_W-1:0]    sum_o,
  output logic [PCOEFF_W-1:0] pcoeff_o,
  output logic [COUNT_W-1:0]  count_o,
  output logic                accept_o,
  output logic                overflow_o
);

  logic                valid_q;
  logic [SUM_W-1:0]    sum_q;
  logic [PCOEFF_W-1:0] pcoeff_q;
  logic [COUNT_W-1:0]  count_q;

  assign accept_o   = valid_q & ready_i;
  // A load only fails when the held total is neither empty nor leaving this cycle.
  assign overflow_o = load_i & valid_q & ~ready_i;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= 1'b0;
      sum_q    <= '0;
      pcoeff_q <= '0;
      count_q  <= '0;
    end else if (load_i && !overflow_o) begin
      valid_q  <= 1'b1;
      sum_q    <= sum_i;
      pcoeff_q <= pcoeff_i;
      count_q  <= count_i;
    end else if (accept_o) begin
      valid_q  <= 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign sum_o    = sum_q;
  assign pcoeff_o = pcoeff_q;
  assign count_o  = count_q;

endmodule
`default_nettype wire

// File: rtl/top_result_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : top_result_accumulator                                         |
// | Brief   : Accumulates per-bot result words into one total per top.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module top_result_accumulator
  import top_result_accumulator_pkg::*;
#(
  parameter int COUNT_W  = 32,
  parameter int SUM_W    = 64,
  parameter int PCOEFF_W = 40
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                startTop,
  input  logic [COUNT_W-1:0]  expectedBots,
  input  logic                resultValid,
  input  logic [63:0]         resultData,
  output logic                doneValid,
  input  logic                doneReady,
  output logic [SUM_W-1:0]    doneSum,
  output logic [PCOEFF_W-1:0] donePcoeff,
  output logic [COUNT_W-1:0]  doneCount,
  output logic                busy,
  output logic [2:0]          errSticky
);

  state_e              state_q;
  logic [COUNT_W-1:0]  exp_q, cnt_q, cnt_d, exp_w;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [PCOEFF_W-1:0] pc_q, pc_d;
  logic [2:0]          err_q;
  logic                w_start, w_active, w_take, w_stray, w_complete;
  logic                w_overflow, w_accept;
  logic                unused_bits;

  assign w_start  = startTop & (state_q == ST_IDLE);
  assign w_active = (state_q == ST_ACCUM) | w_start;
  assign exp_w    = w_start ? expectedBots : exp_q;
  // A zero-length top completes on its start edge, so a word arriving with it has no home.
  assign w_take   = resultValid & ((state_q == ST_ACCUM) | (w_start & (expectedBots != '0)));
  assign w_stray  = resultValid & (state_q == ST_IDLE) & ~(w_start & (expectedBots != '0));

  always_comb begin
    sum_d = sum_q;
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (w_take) begin
      sum_d = sum_q + SUM_W'(resultData[RESULT_SUM_MSB:RESULT_SUM_LSB]);
      pc_d  = pc_q + PCOEFF_W'(resultData[RESULT_PCOEFF_MSB:RESULT_PCOEFF_LSB]);
      cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  assign w_complete = w_active & (cnt_d == exp_w);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      pc_q    <= '0;
      err_q   <= '0;
    end else begin
      err_q[ERR_OVERFLOW] <= err_q[ERR_OVERFLOW] | w_overflow;
      err_q[ERR_STRAY]    <= err_q[ERR_STRAY] | w_stray;
      err_q[ERR_BADSTART] <= err_q[ERR_BADSTART] | (startTop & (state_q == ST_ACCUM));
      if (w_start) begin
        exp_q <= expectedBots;
      end
      if (w_complete) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        sum_q   <= '0;
        pc_q    <= '0;
      end else if (w_active) begin
        state_q <= ST_ACCUM;
        cnt_q   <= cnt_d;
        sum_q   <= sum_d;
        pc_q    <= pc_d;
      end
    end
  end

  top_result_accumulator_hold #(
    .COUNT_W  (COUNT_W),
    .SUM_W    (SUM_W),
    .PCOEFF_W (PCOEFF_W)
  ) u_hold (
    .clock      (clock),
    .resetn     (resetn),
    .load_i     (w_complete),
    .sum_i      (sum_d),
    .pcoeff_i   (pc_d),
    .count_i    (cnt_d),
    .ready_i    (doneReady),
    .valid_o    (doneValid),
    .sum_o      (doneSum),
    .pcoeff_o   (donePcoeff),
    .count_o    (doneCount),
    .accept_o   (w_accept),
    .overflow_o (w_overflow)
  );

  assign busy        = (state_q == ST_ACCUM);
  assign errSticky   = err_q;
  assign unused_bits = ^{resultData[63:51], resultData[47:38], w_accept};

endmodule
`default_nettype wire
